// File: rtl/cfg_regs_pkg.sv
// Purpose: shared register map, transfer FSM encoding and VERSION default for the APB config block.
// Latency: n/a (constants, types and a helper function only).
// Backpressure: n/a.
package cfg_regs_pkg;

  // Word addresses of the register map
  localparam int unsigned ADDR_CTRL     = 0;
  localparam int unsigned ADDR_WAY_EN   = 1;
  localparam int unsigned ADDR_QOS_PRI  = 2;
  localparam int unsigned ADDR_IRQ_STAT = 3;
  localparam int unsigned ADDR_IRQ_MASK = 4;
  localparam int unsigned ADDR_VERSION  = 5;
  localparam int unsigned ADDR_LAST     = ADDR_VERSION;

  // Value presented by the read-only VERSION register unless overridden
  localparam logic [31:0] VERSION_DEFAULT = 32'h0002_0000;

  // Transfer FSM encoding, kept as plain constants for legacy tools
  typedef logic [0:0] fsm_state_t;
  localparam fsm_state_t ST_IDLE   = 1'b0;
  localparam fsm_state_t ST_ACCESS = 1'b1;

  // Wait counter is wide enough for the largest legal wait setting (15)
  localparam int unsigned WAIT_CNT_W = 4;

  // True when a zero-extended word address hits a decoded register
  function automatic logic addr_in_map(input logic [31:0] addr);
    return addr <= 32'(ADDR_LAST);
  endfunction

endpackage

// File: rtl/apb_wait_ctrl.sv
// Purpose: APB transfer sequencer (IDLE/ACCESS) with programmable wait states.
// Latency: pready rises WAIT_CYC cycles after the first access cycle; zero-wait when WAIT_CYC=0.
// Backpressure: slave-side only; pready held low while the wait counter runs, psel drop aborts.
module apb_wait_ctrl
  import cfg_regs_pkg::*;
#(
  parameter int WAIT_CYC = 0
) (
  input  logic pclk,
  input  logic rst_b,
  input  logic psel,
  input  logic penable,
  output logic pready,
  output logic setup,
  output logic done
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LIM = WAIT_CNT_W'(WAIT_CYC);

  fsm_state_t            state;
  fsm_state_t            state_nxt;
  logic [WAIT_CNT_W-1:0] cnt;
  logic [WAIT_CNT_W-1:0] cnt_nxt;

  // Setup phase is only recognised from IDLE so a held psel cannot restart a transfer
  assign setup  = (state == ST_IDLE) & psel & ~penable;
  assign pready = (state == ST_ACCESS) & psel & penable & (cnt == WAIT_LIM);
  assign done   = pready;

  // Next-state and wait-counter logic
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == ST_IDLE) begin
      if (setup) begin
        state_nxt = ST_ACCESS;
        cnt_nxt   = '0;
      end
    end else begin
      if (!psel) begin
        // master abandoned the transfer: nothing commits
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end else if (pready) begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end else if (cnt != WAIT_LIM) begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge pclk) begin
    if (!rst_b) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/apb_cfg_regfile.sv
// Purpose: APB configuration register file driving QoS/way enables and a maskable event interrupt.
// Latency: writes visible on outputs at the completion edge; prdata registered at the setup edge.
// Backpressure: WAIT_CYC wait states per access via pready; errors flagged on pslverr with pready.
module apb_cfg_regfile
  import cfg_regs_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 10,
  parameter int          SLV_NUM    = 3,
  parameter int          PRI_W      = 2,
  parameter int          WAIT_CYC   = 0,
  parameter logic [31:0] VERSION    = VERSION_DEFAULT
) (
  input  logic                       pclk,
  input  logic                       rst_b,
  input  logic                       psel,
  input  logic                       penable,
  input  logic                       pwrite,
  input  logic [ADDR_WIDTH-1:0]      paddr,
  input  logic [DATA_WIDTH-1:0]      pwdata,
  output logic                       pready,
  output logic                       pslverr,
  output logic [DATA_WIDTH-1:0]      prdata,
  input  logic [SLV_NUM-1:0]         evt_in,
  output logic                       qos_en,
  output logic [SLV_NUM-1:0]         way_en,
  output logic [SLV_NUM*PRI_W-1:0]   qos_pri,
  output logic                       irq
);

  localparam int PRI_TOT = SLV_NUM * PRI_W;

  logic                  setup;
  logic                  done;
  logic                  addr_err;
  logic                  wr_commit;
  logic [SLV_NUM-1:0]    irq_stat;
  logic [SLV_NUM-1:0]    irq_mask;
  logic [SLV_NUM-1:0]    stat_clr;
  logic [DATA_WIDTH-1:0] rd_mux;
  logic                  unused_pwdata_par;

  // Register bits beyond the implemented fields are ignored on write
  assign unused_pwdata_par = ^pwdata;

  apb_wait_ctrl #(
    .WAIT_CYC (WAIT_CYC)
  ) u_wait_ctrl (
    .pclk    (pclk),
    .rst_b   (rst_b),
    .psel    (psel),
    .penable (penable),
    .pready  (pready),
    .setup   (setup),
    .done    (done)
  );

  // Out-of-map addresses and any write to VERSION are rejected with no side effects
  assign addr_err  = ~addr_in_map(32'(paddr)) |
                     (pwrite & (paddr == ADDR_WIDTH'(ADDR_VERSION)));
  assign pslverr   = pready & addr_err;
  assign wr_commit = done & pwrite & ~addr_err;

  // W1C clear mask, only populated by a committing write to IRQ_STAT
  assign stat_clr = (wr_commit && (paddr == ADDR_WIDTH'(ADDR_IRQ_STAT))) ?
                    pwdata[SLV_NUM-1:0] : '0;

  assign irq = |(irq_stat & irq_mask);

  // Read data selection; unused bits and unmapped addresses return zero
  always_comb begin
    rd_mux = '0;
    case (paddr)
      ADDR_WIDTH'(ADDR_CTRL):     rd_mux[0]             = qos_en;
      ADDR_WIDTH'(ADDR_WAY_EN):   rd_mux[SLV_NUM-1:0]   = way_en;
      ADDR_WIDTH'(ADDR_QOS_PRI):  rd_mux[PRI_TOT-1:0]   = qos_pri;
      ADDR_WIDTH'(ADDR_IRQ_STAT): rd_mux[SLV_NUM-1:0]   = irq_stat;
      ADDR_WIDTH'(ADDR_IRQ_MASK): rd_mux[SLV_NUM-1:0]   = irq_mask;
      ADDR_WIDTH'(ADDR_VERSION):  rd_mux                = DATA_WIDTH'(VERSION);
      default:                    rd_mux                = '0;
    endcase
  end

  // Read data is captured once at setup and held across the wait states
  always_ff @(posedge pclk) begin
    if (!rst_b) begin
      prdata <= '0;
    end else if (setup) begin
      prdata <= rd_mux;
    end
  end

  // CTRL register: QoS global enable
  always_ff @(posedge pclk) begin
    if (!rst_b) begin
      qos_en <= 1'b0;
    end else if (wr_commit && (paddr == ADDR_WIDTH'(ADDR_CTRL))) begin
      qos_en <= pwdata[0];
    end
  end

  // WAY_EN register: per-slave enables
  always_ff @(posedge pclk) begin
    if (!rst_b) begin
      way_en <= '0;
    end else if (wr_commit && (paddr == ADDR_WIDTH'(ADDR_WAY_EN))) begin
      way_en <= pwdata[SLV_NUM-1:0];
    end
  end

  // QOS_PRI register: packed per-slave priorities
  always_ff @(posedge pclk) begin
    if (!rst_b) begin
      qos_pri <= '0;
    end else if (wr_commit && (paddr == ADDR_WIDTH'(ADDR_QOS_PRI))) begin
      qos_pri <= pwdata[PRI_TOT-1:0];
    end
  end

  // IRQ_MASK register
  always_ff @(posedge pclk) begin
    if (!rst_b) begin
      irq_mask <= '0;
    end else if (wr_commit && (paddr == ADDR_WIDTH'(ADDR_IRQ_MASK))) begin
      irq_mask <= pwdata[SLV_NUM-1:0];
    end
  end

  // IRQ_STAT: events set, W1C clears, and a coincident event beats the clear
  always_ff @(posedge pclk) begin
    if (!rst_b) begin
      irq_stat <= '0;
    end else begin
      irq_stat <= (irq_stat & ~stat_clr) | evt_in;
    end
  end

endmodule

// File: tb/tb_apb_cfg_regfile.sv
// Purpose: self-checking bench for apb_cfg_regfile at zero and three wait states.
// Latency: n/a.
// Backpressure: n/a.
module tb_apb_cfg_regfile;

  logic        pclk;
  logic        rst_b;
  logic        psel    [2];
  logic        penable [2];
  logic        pwrite  [2];
  logic [9:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
  logic [31:0] prdata  [2];
  logic [2:0]  evt_in  [2];
  logic        qos_en  [2];
  logic [2:0]  way_en  [2];
  logic [5:0]  qos_pri [2];
  logic        irq     [2];

  int checks = 0;
  int errors = 0;

  // reference model state, one slot per DUT
  logic        m_qos  [2];
  logic [2:0]  m_way  [2];
  logic [5:0]  m_pri  [2];
  logic [2:0]  m_stat [2];
  logic [2:0]  m_mask [2];
  int          m_wait [2];

  typedef struct {
    logic        wr;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_qos;
    logic [2:0]  exp_way;
    logic [5:0]  exp_pri;
  } vec_t;

  vec_t tbl [13];

  apb_cfg_regfile #(.WAIT_CYC(0)) u_dut0 (
    .pclk(pclk), .rst_b(rst_b), .psel(psel[0]), .penable(penable[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]), .pready(pready[0]), .pslverr(pslverr[0]),
    .prdata(prdata[0]), .evt_in(evt_in[0]), .qos_en(qos_en[0]), .way_en(way_en[0]),
    .qos_pri(qos_pri[0]), .irq(irq[0])
  );

  apb_cfg_regfile #(.WAIT_CYC(3)) u_dut3 (
    .pclk(pclk), .rst_b(rst_b), .psel(psel[1]), .penable(penable[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]), .pready(pready[1]), .pslverr(pslverr[1]),
    .prdata(prdata[1]), .evt_in(evt_in[1]), .qos_en(qos_en[1]), .way_en(way_en[1]),
    .qos_pri(qos_pri[1]), .irq(irq[1])
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_qos[d] = 1'b0; m_way[d] = '0; m_pri[d] = '0; m_stat[d] = '0; m_mask[d] = '0;
    end
  endtask

  // Architectural effect of one completed transfer; expectations taken before the update
  task automatic model_step(input int d, input logic wr, input logic [9:0] a, input logic [31:0] wd,
                            input logic [2:0] evt, output logic [31:0] e_rd, output logic e_err);
    logic [2:0] clr;
    e_err = (a > 10'd5) || (wr && a == 10'd5);
    case (a)
      10'd0:   e_rd = {31'b0, m_qos[d]};
      10'd1:   e_rd = {29'b0, m_way[d]};
      10'd2:   e_rd = {26'b0, m_pri[d]};
      10'd3:   e_rd = {29'b0, m_stat[d]};
      10'd4:   e_rd = {29'b0, m_mask[d]};
      10'd5:   e_rd = 32'h0002_0000;
      default: e_rd = 32'h0;
    endcase
    clr = 3'b000;
    if (wr && !e_err) begin
      case (a)
        10'd0: m_qos[d]  = wd[0];
        10'd1: m_way[d]  = wd[2:0];
        10'd2: m_pri[d]  = wd[5:0];
        10'd3: clr       = wd[2:0];
        10'd4: m_mask[d] = wd[2:0];
        default: ;
      endcase
    end
    m_stat[d] = (m_stat[d] & ~clr) | evt;
  endtask

  // One APB transfer; evt is driven only during the completion cycle. Called #1 after a posedge.
  task automatic apb_xfer(input int d, input logic wr, input logic [9:0] a, input logic [31:0] wd,
                          input logic [2:0] evt, output logic [31:0] rd, output logic err,
                          output int waits, output logic to);
    waits = 0; to = 1'b0; err = 1'b0;
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd;
    @(posedge pclk); #1;
    penable[d] = 1'b1;
    #1;
    while (!pready[d] && !to) begin
      waits++;
      if (waits > 40) to = 1'b1;
      else begin
        @(posedge pclk); #2;
      end
    end
    err = pslverr[d];
    evt_in[d] = evt;
    @(posedge pclk); #1;
    evt_in[d] = '0; psel[d] = 1'b0; penable[d] = 1'b0;
    rd = prdata[d];
  endtask

  task automatic check_outputs(input int d, input string tag);
    chk({tag, "_qos_en"},  32'(qos_en[d]),  32'(m_qos[d]));
    chk({tag, "_way_en"},  32'(way_en[d]),  32'(m_way[d]));
    chk({tag, "_qos_pri"}, 32'(qos_pri[d]), 32'(m_pri[d]));
    chk({tag, "_irq"},     32'(irq[d]),     32'(|(m_stat[d] & m_mask[d])));
  endtask

  task automatic do_xfer(input int d, input logic wr, input logic [9:0] a, input logic [31:0] wd,
                         input logic [2:0] evt);
    logic [31:0] rd, e_rd;
    logic err, e_err, to;
    int waits;
    string tag;
    tag = $sformatf("d%0d_%s%0d", d, wr ? "w" : "r", a);
    model_step(d, wr, a, wd, evt, e_rd, e_err);
    apb_xfer(d, wr, a, wd, evt, rd, err, waits, to);
    chk({tag, "_timeout"}, 32'(to), 32'd0);
    chk({tag, "_pslverr"}, 32'(err), 32'(e_err));
    chk({tag, "_waits"}, 32'(waits), 32'(m_wait[d]));
    if (!wr) chk({tag, "_prdata"}, rd, e_rd);
    check_outputs(d, tag);
  endtask

  task automatic evt_pulse(input int d, input logic [2:0] evt);
    evt_in[d] = evt;
    @(posedge pclk); #1;
    evt_in[d] = '0;
    m_stat[d] = m_stat[d] | evt;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, e_rd;
    logic err, e_err, to;
    int waits;
    logic wr;
    logic [9:0] a;
    logic [31:0] wd;

    tbl[0]  = '{1'b1, 10'd1,    32'h0000_0005, 32'h0,         1'b0, 1'b0, 3'b101, 6'b000000};
    tbl[1]  = '{1'b0, 10'd1,    32'h0,         32'h5,         1'b0, 1'b0, 3'b101, 6'b000000};
    tbl[2]  = '{1'b1, 10'd2,    32'h0000_0024, 32'h0,         1'b0, 1'b0, 3'b101, 6'b100100};
    tbl[3]  = '{1'b0, 10'd2,    32'h0,         32'h24,        1'b0, 1'b0, 3'b101, 6'b100100};
    tbl[4]  = '{1'b1, 10'd0,    32'h0000_0003, 32'h0,         1'b0, 1'b1, 3'b101, 6'b100100};
    tbl[5]  = '{1'b0, 10'd0,    32'h0,         32'h1,         1'b0, 1'b1, 3'b101, 6'b100100};
    tbl[6]  = '{1'b1, 10'd5,    32'h0000_dead, 32'h0,         1'b1, 1'b1, 3'b101, 6'b100100};
    tbl[7]  = '{1'b0, 10'd5,    32'h0,         32'h0002_0000, 1'b0, 1'b1, 3'b101, 6'b100100};
    tbl[8]  = '{1'b0, 10'd9,    32'h0,         32'h0,         1'b1, 1'b1, 3'b101, 6'b100100};
    tbl[9]  = '{1'b1, 10'd9,    32'hffff_ffff, 32'h0,         1'b1, 1'b1, 3'b101, 6'b100100};
    tbl[10] = '{1'b0, 10'd1023, 32'h0,         32'h0,         1'b1, 1'b1, 3'b101, 6'b100100};
    tbl[11] = '{1'b1, 10'd1,    32'hffff_fff8, 32'h0,         1'b0, 1'b1, 3'b000, 6'b100100};
    tbl[12] = '{1'b0, 10'd1,    32'h0,         32'h0,         1'b0, 1'b1, 3'b000, 6'b100100};

    m_wait[0] = 0;
    m_wait[1] = 3;
    rst_b = 1'b0;
    for (int d = 0; d < 2; d++) begin
      psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; evt_in[d] = '0;
    end
    model_reset();
    repeat (3) @(posedge pclk);
    #1;

    // reset state
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst%0d_pready", d),  32'(pready[d]),  32'd0);
      chk($sformatf("rst%0d_pslverr", d), 32'(pslverr[d]), 32'd0);
      chk($sformatf("rst%0d_prdata", d),  prdata[d],       32'd0);
      check_outputs(d, $sformatf("rst%0d", d));
    end
    rst_b = 1'b1;
    @(posedge pclk); #1;

    // reset while in ACCESS of a write to WAY_EN aborts the write
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 10'd1; pwdata[0] = 32'h5;
    @(posedge pclk); #1;
    penable[0] = 1'b1;
    rst_b = 1'b0;
    #1;
    chk("rstmid_pready_before", 32'(pready[0]), 32'd1);
    @(posedge pclk); #1;
    chk("rstmid_way_en", 32'(way_en[0]), 32'd0);
    chk("rstmid_idle_pready", 32'(pready[0]), 32'd0);
    psel[0] = 1'b0; penable[0] = 1'b0; rst_b = 1'b1;
    @(posedge pclk); #1;
    model_reset();

    // directed vectors at zero wait states
    for (int i = 0; i < 13; i++) begin
      model_step(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 3'b000, e_rd, e_err);
      apb_xfer(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, 3'b000, rd, err, waits, to);
      chk($sformatf("tbl%0d_timeout", i), 32'(to), 32'd0);
      chk($sformatf("tbl%0d_waits", i), 32'(waits), 32'd0);
      chk($sformatf("tbl%0d_pslverr", i), 32'(err), 32'(tbl[i].exp_err));
      if (!tbl[i].wr) chk($sformatf("tbl%0d_prdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("tbl%0d_qos_en", i), 32'(qos_en[0]), 32'(tbl[i].exp_qos));
      chk($sformatf("tbl%0d_way_en", i), 32'(way_en[0]), 32'(tbl[i].exp_way));
      chk($sformatf("tbl%0d_qos_pri", i), 32'(qos_pri[0]), 32'(tbl[i].exp_pri));
    end

    // interrupt set / mask / W1C / coincident set-wins
    do_xfer(0, 1'b1, 10'd4, 32'h2, 3'b000);
    evt_pulse(0, 3'b010);
    chk("irq_after_evt", 32'(irq[0]), 32'd1);
    do_xfer(0, 1'b0, 10'd3, 32'h0, 3'b000);
    do_xfer(0, 1'b1, 10'd3, 32'h2, 3'b000);
    chk("irq_after_w1c", 32'(irq[0]), 32'd0);
    do_xfer(0, 1'b0, 10'd3, 32'h0, 3'b000);
    evt_pulse(0, 3'b010);
    do_xfer(0, 1'b1, 10'd3, 32'h2, 3'b010);
    chk("irq_set_wins", 32'(irq[0]), 32'd1);
    do_xfer(0, 1'b0, 10'd3, 32'h0, 3'b000);
    do_xfer(0, 1'b1, 10'd3, 32'h7, 3'b000);

    // three wait states: write CTRL, observe pready and qos_en cycle by cycle
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 10'd0; pwdata[1] = 32'h1;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("w3_cyc%0d_pready", c), 32'(pready[1]), 32'd0);
      chk($sformatf("w3_cyc%0d_pslverr", c), 32'(pslverr[1]), 32'd0);
      chk($sformatf("w3_cyc%0d_qos_en", c), 32'(qos_en[1]), 32'd0);
      @(posedge pclk); #1;
    end
    #1;
    chk("w3_cyc3_pready", 32'(pready[1]), 32'd1);
    chk("w3_cyc3_qos_en", 32'(qos_en[1]), 32'd0);
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    chk("w3_after_qos_en", 32'(qos_en[1]), 32'd1);
    m_qos[1] = 1'b1;

    // psel dropped mid-ACCESS: no update, FSM back to IDLE
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 10'd4; pwdata[1] = 32'h7;
    @(posedge pclk); #1;
    penable[1] = 1'b1;
    @(posedge pclk); #1;
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge pclk); #1;
    do_xfer(1, 1'b0, 10'd4, 32'h0, 3'b000);

    // randomized transfers against the reference model
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 120; n++) begin
        wr = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) a = 10'($urandom);
        else a = 10'($urandom_range(0, 7));
        wd = $urandom;
        do_xfer(d, wr, a, wd, ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
